// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencer with lock and frequency verification
`timescale 1ns/1ps
module pll_lock_supervisor #(
  parameter int GATE_CYCLES    = 50000,
  parameter int EXPECT_COUNT   = 2500,
  parameter int TOL            = 25,
  parameter int STABLE_WINDOWS = 4,
  parameter int RST_PULSE      = 16,
  parameter int LOCK_TIMEOUT   = 100000,
  parameter int MAX_RETRY      = 7
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        locked,
  input  logic        probe,
  output logic        pll_rst,
  output logic        sys_rst,
  output logic        fail,
  output logic [15:0] freq_count,
  output logic        count_valid,
  output logic [2:0]  retry_cnt
);

  localparam int WIN_W   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int TMR_MAX = (LOCK_TIMEOUT > RST_PULSE) ? LOCK_TIMEOUT : RST_PULSE;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int GOOD_W  = $clog2(STABLE_WINDOWS + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  PULSE_LAST = TMR_W'(RST_PULSE - 1);
  localparam logic [TMR_W-1:0]  TMO_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [GOOD_W-1:0] GOOD_TGT   = GOOD_W'(STABLE_WINDOWS);
  localparam logic [15:0]       CNT_LO     = 16'(EXPECT_COUNT - TOL);
  localparam logic [15:0]       CNT_HI     = 16'(EXPECT_COUNT + TOL);
  localparam logic [2:0]        RETRY_MAX  = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_MEASURE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [WIN_W-1:0]  win_cnt;
  logic [15:0]       edge_cnt;
  logic [GOOD_W-1:0] good_cnt;

  logic locked_s1, locked_sync;
  logic probe_s1, probe_s2, probe_d, edge_pulse;

  logic              in_window;
  logic              win_end;
  logic              win_good;
  logic              fail_event;
  logic [15:0]       count_now;
  logic [GOOD_W-1:0] good_next;

  // Bring both asynchronous inputs into refclk and register the probe rising edge
  always_ff @(posedge refclk) begin
    if (rst) begin
      locked_s1   <= 1'b0;
      locked_sync <= 1'b0;
      probe_s1    <= 1'b0;
      probe_s2    <= 1'b0;
      probe_d     <= 1'b0;
      edge_pulse  <= 1'b0;
    end else begin
      locked_s1   <= locked;
      locked_sync <= locked_s1;
      probe_s1    <= probe;
      probe_s2    <= probe_s1;
      probe_d     <= probe_s2;
      edge_pulse  <= probe_s2 & ~probe_d;
    end
  end

  // Window bookkeeping and the failure event for the current cycle
  always_comb begin
    in_window  = (state == S_MEASURE) || (state == S_RUN);
    win_end    = in_window && (win_cnt == WIN_LAST);
    count_now  = (edge_cnt == 16'hFFFF) ? 16'hFFFF : edge_cnt + {15'd0, edge_pulse};
    win_good   = (count_now >= CNT_LO) && (count_now <= CNT_HI);
    good_next  = good_cnt + 1'b1;
    fail_event = 1'b0;
    case (state)
      S_WAIT_LOCK: fail_event = !locked_sync && (timer == TMO_LAST);
      S_MEASURE:   fail_event = !locked_sync;
      S_RUN:       fail_event = !locked_sync || (win_end && !win_good);
      default:     fail_event = 1'b0;
    endcase
  end

  // Supervisor FSM with registered outputs; a failure event overrides normal progress
  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= S_RESET_PLL;
      timer       <= '0;
      win_cnt     <= '0;
      edge_cnt    <= '0;
      good_cnt    <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      fail        <= 1'b0;
      freq_count  <= '0;
      count_valid <= 1'b0;
      retry_cnt   <= '0;
    end else begin
      count_valid <= 1'b0;
      if (in_window) begin
        win_cnt  <= win_end ? '0 : win_cnt + 1'b1;
        edge_cnt <= win_end ? '0 : count_now;
      end
      if (win_end) begin
        freq_count  <= count_now;
        count_valid <= 1'b1;
      end

      if (fail_event) begin
        timer   <= '0;
        sys_rst <= 1'b1;
        if (retry_cnt < RETRY_MAX) begin
          retry_cnt <= retry_cnt + 1'b1;
          state     <= S_RESET_PLL;
          pll_rst   <= 1'b1;
        end else begin
          state   <= S_FAIL;
          pll_rst <= 1'b0;
          fail    <= 1'b1;
        end
      end else begin
        case (state)
          S_RESET_PLL: begin
            if (timer == PULSE_LAST) begin
              state   <= S_WAIT_LOCK;
              pll_rst <= 1'b0;
              timer   <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_WAIT_LOCK: begin
            if (locked_sync) begin
              state    <= S_MEASURE;
              win_cnt  <= '0;
              edge_cnt <= '0;
              good_cnt <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_MEASURE: begin
            if (win_end) begin
              if (!win_good) begin
                good_cnt <= '0;
              end else if (good_next == GOOD_TGT) begin
                state     <= S_RUN;
                sys_rst   <= 1'b0;
                retry_cnt <= '0;
              end else begin
                good_cnt <= good_next;
              end
            end
          end
          S_RUN: begin
            sys_rst <= 1'b0;
          end
          S_FAIL: begin
            pll_rst <= 1'b0;
            sys_rst <= 1'b1;
            fail    <= 1'b1;
          end
          default: state <= S_RESET_PLL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - scoreboard bench for pll_lock_supervisor
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

  localparam int GATE     = 200;
  localparam int EXP      = 25;
  localparam int TOL      = 2;
  localparam int STABLE   = 2;
  localparam int PULSE    = 16;
  localparam int TMO      = 300;
  localparam int MAXR     = 3;
  localparam int GATE_SAT = 131072;

  logic refclk = 1'b0;
  always #5 refclk = ~refclk;

  logic        rst, locked, probe;
  logic        pll_rst, sys_rst, fail, count_valid;
  logic [15:0] freq_count;
  logic [2:0]  retry_cnt;

  logic        rst_s, locked_s, probe_s;
  logic        pll_rst_s, sys_rst_s, fail_s, count_valid_s;
  logic [15:0] freq_count_s;
  logic [2:0]  retry_cnt_s;

  pll_lock_supervisor #(
    .GATE_CYCLES(GATE), .EXPECT_COUNT(EXP), .TOL(TOL), .STABLE_WINDOWS(STABLE),
    .RST_PULSE(PULSE), .LOCK_TIMEOUT(TMO), .MAX_RETRY(MAXR)
  ) dut (
    .refclk(refclk), .rst(rst), .locked(locked), .probe(probe),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .fail(fail),
    .freq_count(freq_count), .count_valid(count_valid), .retry_cnt(retry_cnt)
  );

  pll_lock_supervisor #(
    .GATE_CYCLES(GATE_SAT), .EXPECT_COUNT(EXP), .TOL(TOL), .STABLE_WINDOWS(STABLE),
    .RST_PULSE(PULSE), .LOCK_TIMEOUT(TMO), .MAX_RETRY(MAXR)
  ) dut_sat (
    .refclk(refclk), .rst(rst_s), .locked(locked_s), .probe(probe_s),
    .pll_rst(pll_rst_s), .sys_rst(sys_rst_s), .fail(fail_s),
    .freq_count(freq_count_s), .count_valid(count_valid_s), .retry_cnt(retry_cnt_s)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int   count;
    logic sys_rst;
    logic pll_rst;
    int   retry;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  // Monitor: every window result is popped and compared against the queued expectation
  always @(negedge refclk) begin
    exp_t e;
    if (count_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_window: freq_count %0d with no window expected", freq_count);
      end else begin
        e = exp_q.pop_front();
        check("window_freq_count", freq_count, e.count);
        check("window_sys_rst", sys_rst, e.sys_rst);
        check("window_pll_rst", pll_rst, e.pll_rst);
        check("window_retry_cnt", retry_cnt, e.retry);
      end
    end
  end

  // One 200-cycle probe frame with n rising edges placed well inside the window
  task automatic drive_window(input int n, input logic e_sys, input logic e_pll, input int e_retry);
    exp_t e;
    e.count   = n;
    e.sys_rst = e_sys;
    e.pll_rst = e_pll;
    e.retry   = e_retry;
    exp_q.push_back(e);
    for (int j = 0; j < GATE; j++) begin
      @(negedge refclk);
      probe = (j >= 10) && (j < 10 + 6 * n) && (((j - 10) % 6) < 3);
    end
  endtask

  task automatic wait_pll(input logic lvl, input int lim, input string name);
    int t = 0;
    while (pll_rst !== lvl && t < lim) begin
      @(negedge refclk);
      t++;
    end
    if (pll_rst !== lvl) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: pll_rst got %0b, want %0b within %0d cycles", name, pll_rst, lvl, lim);
    end
  endtask

  task automatic pulse_len(output int n, input int drop_at);
    wait_pll(1'b1, 1000, "pll_rst_rise");
    n = 0;
    while (pll_rst === 1'b1 && n < 2000) begin
      n++;
      if (n == drop_at) locked = 1'b0;
      @(negedge refclk);
    end
  endtask

  task automatic low_len(output int n);
    n = 0;
    while (pll_rst === 1'b0 && fail === 1'b0 && n < 2000) begin
      n++;
      @(negedge refclk);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pll_rst"}, pll_rst, 1);
    check({tag, "_sys_rst"}, sys_rst, 1);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_freq_count"}, freq_count, 0);
    check({tag, "_count_valid"}, count_valid, 0);
    check({tag, "_retry_cnt"}, retry_cnt, 0);
  endtask

  task automatic run_main();
    int n;
    int bad;
    rst = 1'b1; locked = 1'b0; probe = 1'b0;
    repeat (3) @(negedge refclk);
    check_reset_vals("reset");

    // Nominal bring-up
    rst = 1'b0;
    pulse_len(n, -1);
    check("t1_pll_rst_pulse", n, PULSE);
    repeat (49) @(negedge refclk);
    locked = 1'b1;
    drive_window(25, 1'b1, 1'b0, 0);
    drive_window(25, 1'b0, 1'b0, 0);

    // Tolerance bounds: edges of the band pass, one beyond fails in RUN
    drive_window(23, 1'b0, 1'b0, 0);
    drive_window(27, 1'b0, 1'b0, 0);
    drive_window(22, 1'b1, 1'b1, 1);
    repeat (10) @(negedge refclk);
    check("t2_retry_after_bad", retry_cnt, 1);
    locked = 1'b0;
    wait_pll(1'b0, 100, "t2_pll_rst_fall");
    repeat (49) @(negedge refclk);
    locked = 1'b1;
    drive_window(25, 1'b1, 1'b0, 1);
    drive_window(28, 1'b1, 1'b0, 1);
    drive_window(25, 1'b1, 1'b0, 1);
    drive_window(25, 1'b0, 1'b0, 0);

    // Lock loss in RUN landing on the window's terminal cycle
    drive_window(25, 1'b1, 1'b1, 1);
    locked = 1'b0;
    @(negedge refclk);
    locked = 1'b1;
    check("t3_sys_rst_before_latency", sys_rst, 0);
    pulse_len(n, 4);
    check("t3_pll_rst_pulse", n, PULSE);
    check("t3_single_increment", retry_cnt, 1);

    // Lock timeout through all retries into FAIL
    locked = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge refclk);
    rst = 1'b0;
    for (int a = 0; a <= MAXR; a++) begin
      pulse_len(n, -1);
      check("t4_pll_rst_pulse", n, PULSE);
      check("t4_retry_cnt", retry_cnt, a);
      low_len(n);
      check("t4_wait_lock_len", n, TMO);
    end
    check("t4_fail", fail, 1);
    check("t4_pll_rst", pll_rst, 0);
    check("t4_sys_rst", sys_rst, 1);
    check("t4_retry_cnt_final", retry_cnt, MAXR);
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge refclk);
      if (fail !== 1'b1 || pll_rst !== 1'b0 || sys_rst !== 1'b1 ||
          retry_cnt !== 3'(MAXR) || count_valid !== 1'b0) bad++;
    end
    check("t4_fail_hold_bad_cycles", bad, 0);

    // One-cycle rst while in FAIL
    rst = 1'b1;
    @(negedge refclk);
    check_reset_vals("t5_recover");
    rst = 1'b0;
    repeat (5) @(negedge refclk);
  endtask

  task automatic run_sat();
    int t;
    rst_s = 1'b1; locked_s = 1'b1;
    repeat (3) @(negedge refclk);
    rst_s = 1'b0;
    t = 0;
    while (count_valid_s !== 1'b1 && t < 135000) begin
      @(negedge refclk);
      t++;
    end
    check("t5_window_seen", count_valid_s, 1);
    check("t5_freq_count_sat", freq_count_s, 16'hFFFF);
    check("t5_sys_rst_held", sys_rst_s, 1);
    locked_s = 1'b0;
    t = 0;
    while (fail_s !== 1'b1 && t < 3000) begin
      @(negedge refclk);
      t++;
    end
    check("t5_fail", fail_s, 1);
    check("t5_retry_cnt", retry_cnt_s, MAXR);
    check("t5_freq_count_kept", freq_count_s, 16'hFFFF);
    rst_s = 1'b1;
    @(negedge refclk);
    check("t5_rst_pll_rst", pll_rst_s, 1);
    check("t5_rst_sys_rst", sys_rst_s, 1);
    check("t5_rst_fail", fail_s, 0);
    check("t5_rst_freq_count", freq_count_s, 0);
    check("t5_rst_count_valid", count_valid_s, 0);
    check("t5_rst_retry_cnt", retry_cnt_s, 0);
    rst_s = 1'b0;
  endtask

  initial begin
    probe_s = 1'b0;
    forever begin
      @(negedge refclk);
      probe_s = ~probe_s;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      run_main();
      run_sat();
    join
    check("sb_queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
